// File: rtl/sync_fifo_pkg.sv
// Shared constants for the programmable-threshold synchronous FIFO.
package sync_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int af_lvl_default(input int wa);
    return (1 << wa) - 2;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module sync_fifo_ram #(
  parameter int WA = 7,
  parameter int WD = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [WA-1:0] waddr,
  input  logic [WD-1:0] wdata,
  input  logic          re,
  input  logic [WA-1:0] raddr,
  output logic [WD-1:0] rdata
);

  logic [WD-1:0] mem [2**WA];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty levels, sticky error flags,
// and either first-word-fall-through or read-latency-1 output timing.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WA     = 7,
  parameter int WD     = 256,
  parameter int FWFT   = FWFT_ON,
  parameter int AF_LVL = af_lvl_default(WA),
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [WD-1:0] din,
  output logic          full,
  output logic          almost_full,
  input  logic          rd_en,
  output logic [WD-1:0] dout,
  output logic          empty,
  output logic          almost_empty,
  output logic [WA:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [WA:0] DEPTH_C = (WA+1)'(2**WA);
  localparam logic [WA:0] AF_C    = (WA+1)'(AF_LVL);
  localparam logic [WA:0] AE_C    = (WA+1)'(AE_LVL);
  localparam logic [WA:0] ONE_C   = (WA+1)'(1);

  logic [WA:0]   wr_ptr, rd_ptr, count_q;
  logic          vld_p1, dout_live, ovf_q, udf_q;
  logic [WD-1:0] dout_p1;
  logic          wr_acc, rd_acc, ram_re, mem_nonempty;

  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign empty        = (FWFT == FWFT_ON) ? !vld_p1 : (count_q == '0);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc       = wr_en && !full && !flush;
  assign rd_acc       = rd_en && !empty && !flush;
  assign mem_nonempty = (wr_ptr != rd_ptr);

  // In FWFT mode the RAM read register is the output stage: refill it whenever
  // it is empty or being consumed and the array still holds a word.
  always_comb begin
    ram_re = 1'b0;
    if (FWFT == FWFT_ON) ram_re = !flush && mem_nonempty && (!vld_p1 || rd_acc);
    else                 ram_re = rd_acc;
  end

  sync_fifo_ram #(.WA(WA), .WD(WD)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[WA-1:0]),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_ptr[WA-1:0]),
    .rdata (dout_p1)
  );

  // ---- p1: output stage; dout reads zero until the RAM has been read once ----
  assign dout = dout_live ? dout_p1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      vld_p1    <= 1'b0;
      dout_live <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      vld_p1  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (ram_re) begin
        rd_ptr    <= rd_ptr + ONE_C;
        dout_live <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
      if (ram_re)      vld_p1 <= 1'b1;
      else if (rd_acc) vld_p1 <= 1'b0;
      if (wr_en && full)  ovf_q <= 1'b1;
      if (rd_en && empty) udf_q <= 1'b1;
    end
  end

endmodule
